gray_counter_param: RTL and testbench

//   Parametrised modulo-N Gray-code counter, the successor to the fixed 3-bit count-to-6 counter.

---
 rtl/gray_pkg.sv | 20 ++
 rtl/gray_encode.sv | 13 +
 rtl/gray_counter_param.sv | 92 +++++++++
 tb/tb_gray_counter_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and for downstream Gray-pointer consumers.
// Functions operate on MaxWidth bits; callers zero-extend and truncate.
package gray_pkg;

  localparam int unsigned MaxWidth = 16;

  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] gray);
    logic [MaxWidth-1:0] bin;
    bin[MaxWidth-1] = gray[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray encoder, WIDTH bits wide.
module gray_encode
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(MaxWidth'(bin)));

endmodule

// File: rtl/gray_counter_param.sv
// Modulo-MODULO up/down Gray counter with load, clear, hold and registered wrap/load_err pulses.
// Gray output is encoded from the next binary count so both outputs change on the same edge.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned MODULO = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             load_err
);

  if (WIDTH < 2 || WIDTH > MaxWidth || MODULO < 2 || MODULO > (32'd1 << WIDTH)) begin : g_bad_params
    $error("gray_counter_param: illegal WIDTH/MODULO");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      // load_val <= MAX_CNT is the same test as load_val < MODULO, kept in WIDTH bits
      if (load_val <= MAX_CNT) begin
        bin_d = load_val;
      end else begin
        bin_d = '0;
        err_d = 1'b1;
      end
    end else if (enable) begin
      if (up) begin
        if (bin_q == MAX_CNT) begin
          bin_d  = '0;
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end else begin
        if (bin_q == '0) begin
          bin_d  = MAX_CNT;
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end
    end
  end

  gray_encode #(
    .WIDTH(WIDTH)
  ) u_gray_encode (
    .bin (bin_d),
    .gray(gray_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: a 3-bit modulo-7 instance and a 4-bit modulo-16 instance.
module tb_gray_counter_param;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clr, enable, up, load;
  logic [2:0] load_val;
  logic [3:0] load_val4;
  logic [2:0] gray3, bin3;
  logic [3:0] gray4, bin4;
  logic       wrap3, err3, wrap4, err4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(3), .MODULO(7)) dut (
    .clk(clk), .rst(rst), .clr(clr), .enable(enable), .up(up), .load(load),
    .load_val(load_val), .gray_out(gray3), .bin_out(bin3), .wrap(wrap3), .load_err(err3)
  );

  gray_counter_param #(.WIDTH(4), .MODULO(16)) dut16 (
    .clk(clk), .rst(rst), .clr(clr), .enable(enable), .up(up), .load(load),
    .load_val(load_val4), .gray_out(gray4), .bin_out(bin4), .wrap(wrap4), .load_err(err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_gray [8];
    logic [2:0] exp_bin [8];
    exp_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b000, 3'b001};
    exp_bin  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
    #3;
    checks++;
    if ({gray3, bin3, wrap3, err3} !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial: got gray=%b bin=%0d wrap=%b err=%b, need all 0",
               gray3, bin3, wrap3, err3);
    end
    rst = 1'b1; enable = 1'b1; up = 1'b1;
    repeat (4) step();
    checks++;
    if (bin3 !== 3'd4) begin
      errors++;
      $display("FAIL reset_precount: got bin=%0d, need 4", bin3);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({gray3, bin3, wrap3, err3} !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: got gray=%b bin=%0d wrap=%b err=%b, need all 0",
               gray3, bin3, wrap3, err3);
    end
    step();
    checks++;
    if (bin3 !== 3'd0) begin
      errors++;
      $display("FAIL reset_held: got bin=%0d, need 0", bin3);
    end
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (gray3 !== exp_gray[i] || bin3 !== exp_bin[i] || wrap3 !== (i == 6)) begin
        errors++;
        $display("FAIL up_count[%0d]: got gray=%b bin=%0d wrap=%b, need gray=%b bin=%0d wrap=%b",
                 i, gray3, bin3, wrap3, exp_gray[i], exp_bin[i], (i == 6));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_down();
    clr = 1'b1;
    step();
    clr = 1'b0; enable = 1'b1; up = 1'b0;
    step();
    checks++;
    if (bin3 !== 3'd6 || gray3 !== 3'b101 || wrap3 !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got bin=%0d gray=%b wrap=%b, need 6 101 1", bin3, gray3, wrap3);
    end
    step();
    checks++;
    if (bin3 !== 3'd5 || gray3 !== 3'b111 || wrap3 !== 1'b0) begin
      errors++;
      $display("FAIL down_step: got bin=%0d gray=%b wrap=%b, need 5 111 0", bin3, gray3, wrap3);
    end
    enable = 1'b0;
  endtask

  task automatic test_hold_clear();
    load = 1'b1; load_val = 3'd3;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bin3 !== 3'd3 || gray3 !== 3'b010 || wrap3 !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got bin=%0d gray=%b wrap=%b, need 3 010 0",
                 i, bin3, gray3, wrap3);
      end
    end
    clr = 1'b1; load = 1'b1; load_val = 3'd5;
    step();
    checks++;
    if (bin3 !== 3'd0 || gray3 !== 3'b000 || err3 !== 1'b0) begin
      errors++;
      $display("FAIL clr_over_load: got bin=%0d gray=%b err=%b, need 0 000 0", bin3, gray3, err3);
    end
    clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 3'd5;
    step();
    checks++;
    if (bin3 !== 3'd5 || gray3 !== 3'b111 || err3 !== 1'b0) begin
      errors++;
      $display("FAIL load_ok: got bin=%0d gray=%b err=%b, need 5 111 0", bin3, gray3, err3);
    end
    load_val = 3'd7;
    step();
    checks++;
    if (bin3 !== 3'd0 || gray3 !== 3'b000 || err3 !== 1'b1) begin
      errors++;
      $display("FAIL load_range: got bin=%0d gray=%b err=%b, need 0 000 1", bin3, gray3, err3);
    end
    load = 1'b0;
    step();
    checks++;
    if (err3 !== 1'b0 || bin3 !== 3'd0) begin
      errors++;
      $display("FAIL load_err_pulse: got err=%b bin=%0d, need 0 0", err3, bin3);
    end
    load = 1'b1; enable = 1'b1; up = 1'b1; load_val = 3'd2;
    step();
    checks++;
    if (bin3 !== 3'd2 || gray3 !== 3'b011) begin
      errors++;
      $display("FAIL load_over_enable: got bin=%0d gray=%b, need 2 011", bin3, gray3);
    end
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_pow2();
    logic [3:0] prev_gray;
    logic [3:0] exp_bin;
    clr = 1'b1;
    step();
    clr = 1'b0; enable = 1'b1;
    for (int dir = 1; dir >= 0; dir--) begin
      up = dir[0];
      exp_bin = bin4;
      prev_gray = gray4;
      for (int i = 0; i < 17; i++) begin
        step();
        exp_bin = dir[0] ? exp_bin + 4'd1 : exp_bin - 4'd1;
        checks++;
        if ($countones(gray4 ^ prev_gray) != 1 || bin4 !== exp_bin ||
            gray2bin(16'(gray4)) !== 16'(bin4) ||
            wrap4 !== (dir[0] ? (exp_bin == 4'd0) : (exp_bin == 4'd15))) begin
          errors++;
          $display("FAIL pow2_sweep[dir=%0d,%0d]: got prev=%b gray=%b bin=%0d wrap=%b, need bin=%0d",
                   dir, i, prev_gray, gray4, bin4, wrap4, exp_bin);
        end
        prev_gray = gray4;
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_reversal();
    logic [2:0] exp_bin [4];
    exp_bin = '{3'd2, 3'd1, 3'd2, 3'd1};
    load = 1'b1; load_val = 3'd1;
    step();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      step();
      checks++;
      if (bin3 !== exp_bin[i] || wrap3 !== 1'b0) begin
        errors++;
        $display("FAIL reversal[%0d]: got bin=%0d wrap=%b, need %0d 0", i, bin3, wrap3, exp_bin[i]);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0;
    load_val = '0; load_val4 = '0;
    test_reset();
    test_down();
    test_hold_clear();
    test_load();
    test_pow2();
    test_reversal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
